// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake between the issuing stage and the ALU op sequencer.
// The sequencer is the slave; the instruction source drives valid/instr.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 4
);
    logic                  instr_valid;
    logic [2*DATA_W-1:0]   instr;
    logic                  instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_op_sequencer.sv
// Control stage for the 4-bit ALU: decodes instructions, sequences the ALU strobes and keeps
// the accumulator and flags. Optional macro ALU_SEQ_STALL_EN adds result_ready back-pressure.
module alu_op_sequencer #(
    parameter int                DATA_W  = 4,
    parameter logic [DATA_W-1:0] ACC_RST = 4'h0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ALU_SEQ_STALL_EN
    input  logic              result_ready,
`endif
    alu_op_sequencer_if.slave ifc,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic              alu_add,
    output logic              alu_sub,
    output logic              alu_lsh,
    output logic              alu_rsh,
    output logic              alu_and,
    output logic              alu_or,
    output logic              alu_xor,
    output logic              alu_inv,
    output logic              alu_clr,
    output logic              alu_lsr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    input  logic              alu_shift_flag,
    output logic [DATA_W-1:0] acc,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              illegal,
    output logic              result_valid
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LSH = 4'h3;
    localparam logic [3:0] OP_RSH = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_INV = 4'h8;
    localparam logic [3:0] OP_CLR = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] acc_nxt;
    logic              carry_nxt;
    logic [8:0]        strobe;
    logic [3:0]        in_op;
    logic [DATA_W-1:0] in_imm;
    logic              accept;

    assign in_op   = ifc.instr[2*DATA_W-1:DATA_W];
    assign in_imm  = ifc.instr[DATA_W-1:0];
    assign accept  = (state == IDLE) && ifc.instr_valid;
    assign alu_in1 = acc;
    assign alu_in2 = imm_q;
    assign {alu_clr, alu_inv, alu_xor, alu_or, alu_and,
            alu_rsh, alu_lsh, alu_sub, alu_add} = strobe;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Every control output is gated by reset so the reset cycle itself is quiet,
    // even when reset lands in the middle of an instruction.
    always_comb begin
        state_nxt       = state;
        ifc.instr_ready = 1'b0;
        alu_lsr         = 1'b0;
        strobe          = '0;
        result_valid    = 1'b0;
        case (state)
            IDLE: begin
                ifc.instr_ready = 1'b1;
                if (ifc.instr_valid)
                    state_nxt = (in_op == OP_LSH || in_op == OP_RSH) ? LOAD : EXEC;
            end
            LOAD: begin
                alu_lsr   = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                if (op_q >= OP_ADD && op_q <= OP_CLR)
                    strobe = 9'd1 << (op_q - 4'd1);
                state_nxt = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
`ifdef ALU_SEQ_STALL_EN
                state_nxt = result_ready ? IDLE : DONE;
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            ifc.instr_ready = 1'b0;
            alu_lsr         = 1'b0;
            strobe          = '0;
            result_valid    = 1'b0;
            state_nxt       = IDLE;
        end
    end

    always_comb begin
        acc_nxt   = acc;
        carry_nxt = carry_flag;
        case (op_q)
            OP_ADD, OP_SUB: begin
                acc_nxt   = alu_out;
                carry_nxt = alu_overflow;
            end
            OP_LSH, OP_RSH: begin
                acc_nxt   = alu_out;
                carry_nxt = alu_shift_flag;
            end
            OP_AND, OP_OR, OP_XOR, OP_INV, OP_CLR: begin
                acc_nxt   = alu_out;
                carry_nxt = 1'b0;
            end
            OP_LDI: begin
                acc_nxt   = imm_q;
                carry_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Operand registers load only on a transfer; results commit only at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= OP_NOP;
            imm_q      <= '0;
            acc        <= ACC_RST;
            carry_flag <= 1'b0;
            zero_flag  <= (ACC_RST == '0);
            illegal    <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= in_op;
                imm_q <= in_imm;
            end
            if (state == EXEC) begin
                acc        <= acc_nxt;
                carry_flag <= carry_nxt;
                zero_flag  <= (acc_nxt == '0);
                if (op_q > OP_LDI) illegal <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream control stage for the 4-bit ALU.
- Accepts 8-bit instructions over a valid/ready handshake and decodes the opcode.
- Drives the ALU's one-hot control strobes, including the two-cycle load-then-shift sequence the ALU shift register needs.
- Captures the ALU result and flags into a 4-bit accumulator; the accumulator feeds the ALU's in1 operand.

Parameters:
DATA_W, 4, accumulator/operand width; must equal ALU width (4); instruction width is 2*DATA_W
ACC_RST, 4'h0, accumulator value after reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr  input  8  [7:4] opcode, [3:0] immediate operand
instr_ready  output  1  sequencer can accept an instruction (high only in IDLE)
alu_in1  output  4  ALU operand 1 = acc
alu_in2  output  4  ALU operand 2 = registered immediate
alu_add, alu_sub, alu_lsh, alu_rsh, alu_and, alu_or, alu_xor, alu_inv, alu_clr  output  1 each  one-hot ALU op strobes
alu_lsr  output  1  ALU shift-register load enable
alu_out  input  4  ALU result
alu_overflow  input  1  ALU carry/borrow
alu_shift_flag  input  1  ALU shifted-out bit
acc  output  4  accumulator
carry_flag  output  1  last carry/borrow/shift-out
zero_flag  output  1  acc == 0 after last write
illegal  output  1  sticky: illegal opcode seen
result_valid  output  1  acc/flags updated by the completed instruction

Behaviour:
- Opcodes:
  - 0 NOP; 1 ADD; 2 SUB; 3 LSH; 4 RSH; 5 AND; 6 OR; 7 XOR; 8 INV; 9 CLR.
  - A LDI: acc <= imm, no ALU strobe.
  - B-F illegal: executed as NOP; sets illegal.
- Reset (synchronous, active-high), including mid-operation:
  - state = IDLE, acc = ACC_RST, imm register = 0.
  - carry_flag = 0, zero_flag = 1 (when ACC_RST = 0), illegal = 0.
  - All strobes = 0, alu_lsr = 0, result_valid = 0, instr_ready = 0 during the reset cycle.
  - Reset has priority over all other events.
- FSM states: IDLE, LOAD, EXEC, DONE.
  - IDLE: instr_ready = 1. On instr_valid, capture the opcode and imm. Go to LOAD for opcodes 3/4, otherwise go to EXEC.
  - LOAD (shifts only): alu_lsr = 1 for exactly one cycle, so the ALU shift register samples acc at the end of LOAD. Next state EXEC.
  - EXEC: assert exactly one strobe matching the opcode (none for NOP/LDI/illegal). At the end of EXEC:
    - acc <= alu_out (ADD..CLR), imm (LDI), or unchanged (NOP/illegal).
    - carry_flag <= alu_overflow for ADD/SUB; <= alu_shift_flag for LSH/RSH; <= 0 for AND/OR/XOR/INV/CLR/LDI; unchanged for NOP/illegal.
    - zero_flag <= (new acc == 0).
    - Next state DONE.
  - DONE: result_valid = 1 for exactly one cycle. Next state IDLE.
- Latency (instruction accepted at edge N):
  - Non-shift: EXEC is cycle N+1; result_valid is high in cycle N+2.
  - Shift: LOAD is N+1, EXEC is N+2; result_valid is high in N+3.
- Throughput: one instruction per 3 cycles (4 for shifts).
- Handshake: a transfer occurs only when instr_valid && instr_ready. instr_valid outside IDLE is ignored (no capture, no side effect).
- Strobes are zero in every state except EXEC. At most one strobe is high in any cycle.
- alu_in1/alu_in2 are registered values, stable from the start of LOAD/EXEC through the end of EXEC.
- Arithmetic wraps mod 16. Carry semantics come from the ALU: SUB borrow gives carry = 1 when imm > acc.

Optional Feature:
- Macro: ALU_SEQ_STALL_EN.
- Defined:
  - Adds input port result_ready (1 bit).
  - DONE holds result_valid = 1, with acc/flags stable, until result_ready = 1; then goes to IDLE.
  - Reset still clears immediately.
- Undefined:
  - No result_ready port.
  - DONE lasts exactly one cycle, as specified above.

Test Plan:
- Reset, then LDI 0x5, then ADD 0x3 -> result_valid in 2nd cycle after acceptance; acc=0x8, carry=0, zero=0.
- acc=0xF, ADD 0x1 -> acc=0x0, carry=1, zero=1; SUB 0x1 from acc=0x0 -> acc=0xF, carry=1.
- acc=0x9, LSH -> alu_lsr high exactly 1 cycle before alu_lsh; acc=0x2, carry=1, result_valid in 3rd cycle after acceptance. Then RSH -> acc=0x1, carry=0.
- acc=0xC: AND 0xA -> 0x8; OR 0x3 -> 0xB; XOR 0xF -> 0x4; INV -> 0xB; CLR -> 0x0 with zero=1. Carry=0 after each; strobe one-hot every cycle.
- Opcode 0xE -> acc unchanged, illegal=1 and stays 1 through further valid ops until reset. instr_valid held high in EXEC/DONE -> no extra capture.
- Assert reset during EXEC of ADD -> next cycle acc=0, state IDLE, no result_valid. With ALU_SEQ_STALL_EN, result_ready=0 for 3 cycles -> result_valid held 3+ cycles, instr_ready=0 throughout.
